regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 68 ++++++
 tb/tb_regfile_sb.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard: two combinational read ports,
// one write-back port that retires a producer, one alloc port that issues one.
module regfile_sb #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_W    = 2,
    parameter bit BYPASS    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ADDR_W-1:0]    rd_addr1,
    input  logic [ADDR_W-1:0]    rd_addr2,
    output logic [WORD_SIZE-1:0] rd_data1,
    output logic [WORD_SIZE-1:0] rd_data2,
    output logic                 rd_busy1,
    output logic                 rd_busy2,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic                 alloc_en,
    input  logic [ADDR_W-1:0]    alloc_addr,
    output logic [ADDR_W:0]      busy_cnt
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REGS-1:0][WORD_SIZE-1:0] regs;
    logic [NUM_REGS-1:0]                busy;
    logic [NUM_REGS-1:0]                busy_nxt;
    logic [ADDR_W:0]                    cnt_nxt;
    logic                               fwd1;
    logic                               fwd2;

    // Clear before set so an alloc to the register being written keeps it busy.
    always_comb begin
        busy_nxt = busy;
        if (we)
            busy_nxt[wr_addr] = 1'b0;
        if (alloc_en)
            busy_nxt[alloc_addr] = 1'b1;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++)
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            regs     <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (we)
                regs[wr_addr] <= wr_data;
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // A forwarded read sees the value being retired, so its producer is no longer pending.
    assign fwd1 = BYPASS && we && (wr_addr == rd_addr1);
    assign fwd2 = BYPASS && we && (wr_addr == rd_addr2);

    assign rd_data1 = fwd1 ? wr_data : regs[rd_addr1];
    assign rd_data2 = fwd2 ? wr_data : regs[rd_addr2];
    assign rd_busy1 = fwd1 ? 1'b0 : busy[rd_addr1];
    assign rd_busy2 = fwd2 ? 1'b0 : busy[rd_addr2];
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table for the corner cases, then random
// traffic on a forwarding and a non-forwarding instance against an array model.
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  rd_addr1, rd_addr2, wr_addr, alloc_addr;
    logic        we, alloc_en;
    logic [15:0] wr_data;

    logic [15:0] d1a, d2a, d1b, d2b;
    logic        b1a, b2a, b1b, b2b;
    logic [2:0]  cnta, cntb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_sb #(.WORD_SIZE(16), .ADDR_W(2), .BYPASS(1'b1)) dut_byp (
        .clk(clk), .reset_n(reset_n),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(d1a), .rd_data2(d2a), .rd_busy1(b1a), .rd_busy2(b2a),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_cnt(cnta)
    );

    regfile_sb #(.WORD_SIZE(16), .ADDR_W(2), .BYPASS(1'b0)) dut_nobyp (
        .clk(clk), .reset_n(reset_n),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(d1b), .rd_data2(d2b), .rd_busy1(b1b), .rd_busy2(b2b),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_cnt(cntb)
    );

    typedef struct {
        logic        rn, we;
        logic [1:0]  wa;
        logic [15:0] wd;
        logic        ae;
        logic [1:0]  aa, ra1, ra2;
        logic [15:0] d1;
        logic        b1;
        logic [15:0] d1nb;
        logic [15:0] d2;
        logic        b2;
        logic [2:0]  cnt;
    } vec_t;

    vec_t tbl[18];

    // Reference state: plain arrays updated from the architectural rules.
    int m_reg[4];
    bit m_busy[4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int exp_data(input int addr, input bit byp);
        if (byp && we && int'(wr_addr) == addr) return int'(wr_data);
        return m_reg[addr];
    endfunction

    function automatic int exp_busy(input int addr, input bit byp);
        if (byp && we && int'(wr_addr) == addr) return 0;
        return int'(m_busy[addr]);
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        foreach (m_busy[i]) if (m_busy[i]) n++;
        return n;
    endfunction

    task automatic model_edge();
        if (!reset_n) begin
            foreach (m_reg[i]) begin m_reg[i] = 0; m_busy[i] = 0; end
        end else begin
            if (we) begin
                m_reg[wr_addr] = int'(wr_data);
                m_busy[wr_addr] = 0;
            end
            if (alloc_en) m_busy[alloc_addr] = 1;
        end
    endtask

    initial begin
        tbl[0]  = '{1,1,1,16'h1234,0,0,1,0, 16'h1234,0,16'h0000, 16'h0000,0,0};
        tbl[1]  = '{0,0,0,16'h0000,0,0,1,0, 16'h1234,0,16'h1234, 16'h0000,0,0};
        tbl[2]  = '{1,0,0,16'h0000,0,0,1,0, 16'h0000,0,16'h0000, 16'h0000,0,0};
        tbl[3]  = '{1,1,2,16'hBEEF,0,0,2,2, 16'hBEEF,0,16'h0000, 16'hBEEF,0,0};
        tbl[4]  = '{1,0,0,16'h0000,1,3,2,3, 16'hBEEF,0,16'hBEEF, 16'h0000,0,0};
        tbl[5]  = '{1,0,0,16'h0000,0,0,2,3, 16'hBEEF,0,16'hBEEF, 16'h0000,1,1};
        tbl[6]  = '{1,1,3,16'h00A5,0,0,3,3, 16'h00A5,0,16'h0000, 16'h00A5,0,1};
        tbl[7]  = '{1,0,0,16'h0000,0,0,3,3, 16'h00A5,0,16'h00A5, 16'h00A5,0,0};
        tbl[8]  = '{1,0,0,16'h0000,1,1,1,0, 16'h0000,0,16'h0000, 16'h0000,0,0};
        tbl[9]  = '{1,1,1,16'h5555,1,1,1,0, 16'h5555,0,16'h0000, 16'h0000,0,1};
        tbl[10] = '{1,0,0,16'h0000,0,0,1,0, 16'h5555,1,16'h5555, 16'h0000,0,1};
        tbl[11] = '{1,0,0,16'h0000,1,0,1,0, 16'h5555,1,16'h5555, 16'h0000,0,1};
        tbl[12] = '{1,0,0,16'h0000,1,2,1,0, 16'h5555,1,16'h5555, 16'h0000,1,2};
        tbl[13] = '{1,0,0,16'h0000,1,3,0,2, 16'h0000,1,16'h0000, 16'hBEEF,1,3};
        tbl[14] = '{1,0,0,16'h0000,1,0,0,3, 16'h0000,1,16'h0000, 16'h00A5,1,4};
        tbl[15] = '{1,0,0,16'h0000,0,0,0,1, 16'h0000,1,16'h0000, 16'h5555,1,4};
        tbl[16] = '{0,1,0,16'hFFFF,1,2,3,2, 16'h00A5,1,16'h00A5, 16'hBEEF,1,4};
        tbl[17] = '{1,0,0,16'h0000,0,0,0,2, 16'h0000,0,16'h0000, 16'h0000,0,0};

        reset_n = 1'b0; we = 0; alloc_en = 0; wr_addr = 0; wr_data = 0;
        alloc_addr = 0; rd_addr1 = 1; rd_addr2 = 3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rd_data1", int'(d1a), 0);
        chk("reset_rd_data2", int'(d2a), 0);
        chk("reset_rd_busy1", int'(b1a), 0);
        chk("reset_busy_cnt", int'(cnta), 0);
        chk("reset_busy_cnt_nobyp", int'(cntb), 0);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            reset_n = tbl[i].rn; we = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
            alloc_en = tbl[i].ae; alloc_addr = tbl[i].aa;
            rd_addr1 = tbl[i].ra1; rd_addr2 = tbl[i].ra2;
            #2;
            chk($sformatf("vec%0d_rd_data1", i), int'(d1a), int'(tbl[i].d1));
            chk($sformatf("vec%0d_rd_busy1", i), int'(b1a), int'(tbl[i].b1));
            chk($sformatf("vec%0d_rd_data2", i), int'(d2a), int'(tbl[i].d2));
            chk($sformatf("vec%0d_rd_busy2", i), int'(b2a), int'(tbl[i].b2));
            chk($sformatf("vec%0d_busy_cnt", i), int'(cnta), int'(tbl[i].cnt));
            chk($sformatf("vec%0d_nobyp_rd_data1", i), int'(d1b), int'(tbl[i].d1nb));
            chk($sformatf("vec%0d_nobyp_busy_cnt", i), int'(cntb), int'(tbl[i].cnt));
        end

        // Random traffic; first cycle forces a reset to align the model.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            reset_n    = (i == 0) ? 1'b0 : ($urandom_range(0, 19) != 0);
            we         = $urandom_range(0, 1) == 1;
            wr_addr    = 2'($urandom_range(0, 3));
            wr_data    = 16'($urandom);
            alloc_en   = $urandom_range(0, 2) != 0;
            alloc_addr = 2'($urandom_range(0, 3));
            rd_addr1   = 2'($urandom_range(0, 3));
            rd_addr2   = ($urandom_range(0, 3) == 0) ? wr_addr : 2'($urandom_range(0, 3));
            #2;
            if (i > 0) begin
                chk("rnd_byp_rd_data1", int'(d1a), exp_data(int'(rd_addr1), 1));
                chk("rnd_byp_rd_data2", int'(d2a), exp_data(int'(rd_addr2), 1));
                chk("rnd_byp_rd_busy1", int'(b1a), exp_busy(int'(rd_addr1), 1));
                chk("rnd_byp_rd_busy2", int'(b2a), exp_busy(int'(rd_addr2), 1));
                chk("rnd_byp_busy_cnt", int'(cnta), exp_cnt());
                chk("rnd_nobyp_rd_data1", int'(d1b), exp_data(int'(rd_addr1), 0));
                chk("rnd_nobyp_rd_data2", int'(d2b), exp_data(int'(rd_addr2), 0));
                chk("rnd_nobyp_rd_busy1", int'(b1b), exp_busy(int'(rd_addr1), 0));
                chk("rnd_nobyp_rd_busy2", int'(b2b), exp_busy(int'(rd_addr2), 0));
                chk("rnd_nobyp_busy_cnt", int'(cntb), exp_cnt());
            end
            @(posedge clk);
            model_edge();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
